// File: rtl/bev_pkg.sv
`default_nettype none
// ============================================================================
// Module : bev_pkg
// Brief  : Shared types, state encoding and date helper for the BEV controller
// Rev    : 1.0
// ============================================================================
package bev_pkg;

    localparam int c_DATE_W = 9;

    typedef enum logic [1:0] {
        ACT_MAKE   = 2'd0,
        ACT_SUPPLY = 2'd1,
        ACT_CHECK  = 2'd2
    } bev_act_e;

    typedef enum logic [1:0] {
        ERR_NO_ERR = 2'd0,
        ERR_NO_EXP = 2'd1,
        ERR_NO_ING = 2'd2,
        ERR_ING_OF = 2'd3
    } bev_err_e;

    typedef struct packed {
        logic [3:0] mon;
        logic [4:0] day;
    } date_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_CALC    = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_RESP    = 3'd5
    } bev_state_e;

    // Same-day is still fresh; only a strictly later date has expired.
    function automatic logic is_expired(input date_t today, input date_t rec);
        return (today.mon > rec.mon) ||
               ((today.mon == rec.mon) && (today.day > rec.day));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bev_rec_cache.sv
`default_nettype none
// ============================================================================
// Module : bev_rec_cache
// Brief  : One-entry write-through record cache with lookup/fill/update/flush
// Rev    : 1.0
// ============================================================================
module bev_rec_cache
    import bev_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int REC_W  = 57
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [REC_W-1:0]  lookup_rec,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [REC_W-1:0]  fill_rec,
    input  logic              upd_en,
    input  logic [REC_W-1:0]  upd_rec
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [REC_W-1:0]  r_rec;

    assign lookup_hit = r_valid && (r_addr == lookup_addr);
    assign lookup_rec = r_rec;

    // Update only rewrites data: the entry already holds the active address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_rec   <= '0;
        end else begin
            if (fill_en) begin
                r_valid <= 1'b1;
                r_addr  <= fill_addr;
                r_rec   <= fill_rec;
            end else if (upd_en) begin
                r_rec   <= upd_rec;
            end
            if (flush) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bev_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bev_param_ctrl
// Brief  : Parametrised beverage-station command controller with record cache
// Rev    : 1.0
// ============================================================================
module bev_param_ctrl
    import bev_pkg::*;
#(
    parameter int NUM_ING = 4,
    parameter int ING_W   = 12,
    parameter int ADDR_W  = 8,
    parameter int REC_W   = NUM_ING*ING_W+9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_act,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [8:0]               cmd_date,
    input  logic [NUM_ING*ING_W-1:0] cmd_amt,
    input  logic                     cache_flush,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [REC_W-1:0]         mem_req_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [REC_W-1:0]         mem_rsp_rdata,
    output logic                     out_valid,
    output logic [1:0]               err_msg,
    output logic [NUM_ING-1:0]       err_mask,
    output logic                     complete
);

    localparam int c_ING_BITS = NUM_ING*ING_W;

    bev_state_e              r_state, w_next;
    bev_act_e                r_act, w_cmd_act;
    logic [ADDR_W-1:0]       r_addr;
    date_t                   r_date;
    logic [c_ING_BITS-1:0]   r_amt;
    logic [REC_W-1:0]        r_rec;
    bev_err_e                r_err, w_calc_err;
    logic [NUM_ING-1:0]      r_mask, w_calc_mask;
    logic [REC_W-1:0]        w_calc_rec, w_cache_rec;
    logic                    w_calc_wr, w_hit, w_expired;
    logic [NUM_ING-1:0]      w_short, w_ovf;
    logic [c_ING_BITS-1:0]   w_ing_sub, w_ing_add;

    bev_rec_cache #(.ADDR_W(ADDR_W), .REC_W(REC_W)) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (cache_flush),
        .lookup_addr (cmd_addr),
        .lookup_hit  (w_hit),
        .lookup_rec  (w_cache_rec),
        .fill_en     ((r_state == ST_RD_WAIT) && mem_rsp_valid),
        .fill_addr   (r_addr),
        .fill_rec    (mem_rsp_rdata),
        .upd_en      ((r_state == ST_CALC) && w_calc_wr),
        .upd_rec     (w_calc_rec)
    );

    for (genvar i = 0; i < NUM_ING; i++) begin : g_ing
        logic [ING_W-1:0] w_have, w_need;
        logic [ING_W:0]   w_sum;
        assign w_have = r_rec[9+i*ING_W +: ING_W];
        assign w_need = r_amt[i*ING_W +: ING_W];
        assign w_sum  = {1'b0, w_have} + {1'b0, w_need};
        assign w_short[i] = (w_have < w_need);
        assign w_ovf[i]   = w_sum[ING_W];
        assign w_ing_sub[i*ING_W +: ING_W] = w_have - w_need;
        assign w_ing_add[i*ING_W +: ING_W] = w_sum[ING_W] ? {ING_W{1'b1}} : w_sum[ING_W-1:0];
    end

    assign w_expired = is_expired(r_date, date_t'(r_rec[8:0]));

    always_comb begin
        case (cmd_act)
            2'd0:    w_cmd_act = ACT_MAKE;
            2'd1:    w_cmd_act = ACT_SUPPLY;
            default: w_cmd_act = ACT_CHECK;
        endcase
    end

    // Make: expiry outranks shortage. Supply: always written back, even saturated.
    always_comb begin
        w_calc_err  = ERR_NO_ERR;
        w_calc_mask = '0;
        w_calc_rec  = r_rec;
        w_calc_wr   = 1'b0;
        case (r_act)
            ACT_MAKE: begin
                if (w_expired) begin
                    w_calc_err = ERR_NO_EXP;
                end else if (|w_short) begin
                    w_calc_err  = ERR_NO_ING;
                    w_calc_mask = w_short;
                end else begin
                    w_calc_rec = {w_ing_sub, r_rec[8:0]};
                    w_calc_wr  = 1'b1;
                end
            end
            ACT_SUPPLY: begin
                w_calc_rec = {w_ing_add, r_date};
                w_calc_wr  = 1'b1;
                if (|w_ovf) begin
                    w_calc_err  = ERR_ING_OF;
                    w_calc_mask = w_ovf;
                end
            end
            default: begin
                if (w_expired) begin
                    w_calc_err = ERR_NO_EXP;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (cmd_valid)     w_next = w_hit ? ST_CALC : ST_RD_REQ;
            ST_RD_REQ:  if (mem_req_ready) w_next = ST_RD_WAIT;
            ST_RD_WAIT: if (mem_rsp_valid) w_next = ST_CALC;
            ST_CALC:                       w_next = w_calc_wr ? ST_WR_REQ : ST_RESP;
            ST_WR_REQ:  if (mem_req_ready) w_next = ST_RESP;
            ST_RESP:                       w_next = ST_IDLE;
            default:                       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act  <= ACT_CHECK;
            r_addr <= '0;
            r_date <= '0;
            r_amt  <= '0;
            r_rec  <= '0;
            r_err  <= ERR_NO_ERR;
            r_mask <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_act  <= w_cmd_act;
                        r_addr <= cmd_addr;
                        r_date <= cmd_date;
                        r_amt  <= cmd_amt;
                        if (w_hit) r_rec <= w_cache_rec;
                    end
                end
                ST_RD_WAIT: if (mem_rsp_valid) r_rec <= mem_rsp_rdata;
                ST_CALC: begin
                    r_rec  <= w_calc_rec;
                    r_err  <= w_calc_err;
                    r_mask <= w_calc_mask;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready     = (r_state == ST_IDLE);
    assign mem_req_valid = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
    assign mem_req_we    = (r_state == ST_WR_REQ);
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_rec;
    assign out_valid     = (r_state == ST_RESP);
    assign err_msg       = out_valid ? r_err : ERR_NO_ERR;
    assign err_mask      = out_valid ? r_mask : '0;
    assign complete      = out_valid && (r_err == ERR_NO_ERR);

endmodule
`default_nettype wire

// File: tb/tb_bev_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_bev_param_ctrl
// Brief  : Directed bench for bev_param_ctrl at 4x12 and 6x10 configurations
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bev_param_ctrl;

    localparam int c_R0 = 57;
    localparam int c_M0 = 48;
    localparam int c_R1 = 69;
    localparam int c_M1 = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4 x 12-bit instance
    logic             rst_n, cmd_valid, cmd_ready, cache_flush;
    logic [1:0]       cmd_act, err_msg;
    logic [7:0]       cmd_addr, mem_req_addr;
    logic [8:0]       cmd_date;
    logic [c_M0-1:0]  cmd_amt;
    logic             mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
    logic [c_R0-1:0]  mem_req_wdata, mem_rsp_rdata;
    logic             out_valid, complete;
    logic [3:0]       err_mask;

    // 6 x 10-bit instance
    logic             rst_n_1, cmd_valid_1, cmd_ready_1, cache_flush_1;
    logic [1:0]       cmd_act_1, err_msg_1;
    logic [7:0]       cmd_addr_1, mem_req_addr_1;
    logic [8:0]       cmd_date_1;
    logic [c_M1-1:0]  cmd_amt_1;
    logic             mem_req_valid_1, mem_req_ready_1, mem_req_we_1, mem_rsp_valid_1;
    logic [c_R1-1:0]  mem_req_wdata_1, mem_rsp_rdata_1;
    logic             out_valid_1, complete_1;
    logic [5:0]       err_mask_1;

    bev_param_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_act(cmd_act), .cmd_addr(cmd_addr), .cmd_date(cmd_date), .cmd_amt(cmd_amt),
        .cache_flush(cache_flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .out_valid(out_valid),
        .err_msg(err_msg), .err_mask(err_mask), .complete(complete)
    );

    bev_param_ctrl #(.NUM_ING(6), .ING_W(10), .ADDR_W(8)) u_dut_1 (
        .clk(clk), .rst_n(rst_n_1), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
        .cmd_act(cmd_act_1), .cmd_addr(cmd_addr_1), .cmd_date(cmd_date_1), .cmd_amt(cmd_amt_1),
        .cache_flush(cache_flush_1), .mem_req_valid(mem_req_valid_1), .mem_req_ready(mem_req_ready_1),
        .mem_req_we(mem_req_we_1), .mem_req_addr(mem_req_addr_1), .mem_req_wdata(mem_req_wdata_1),
        .mem_rsp_valid(mem_rsp_valid_1), .mem_rsp_rdata(mem_rsp_rdata_1), .out_valid(out_valid_1),
        .err_msg(err_msg_1), .err_mask(err_mask_1), .complete(complete_1)
    );

    logic [c_R0-1:0] mem0 [0:255];
    int n_checks = 0;
    int n_errors = 0;

    int              r_lat, r_nrd, r_nwr;
    logic [1:0]      r_err;
    logic [3:0]      r_mask;
    logic            r_cmp, r_stable;
    logic [c_R0-1:0] r_wd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_R0-1:0] rec4(input logic [11:0] i3, i2, i1, i0,
                                              input logic [3:0] m, input logic [4:0] d);
        return {i3, i2, i1, i0, m, d};
    endfunction

    // Issue one command and play memory for the 4x12 instance; latency counts from the accept edge.
    task automatic run_cmd(input logic [1:0] act, input logic [7:0] addr, input logic [8:0] date,
                           input logic [c_M0-1:0] amt, input int stall);
        logic            rsp_due, have_cap;
        logic [7:0]      rsp_addr;
        logic [c_R0+8:0] cap;
        int              stall_left;
        rsp_due = 0; have_cap = 0; rsp_addr = 0; cap = '0; stall_left = stall;
        r_lat = -1; r_nrd = 0; r_nwr = 0; r_err = 'x; r_mask = 'x; r_cmp = 'x;
        r_stable = 1; r_wd = '0;
        @(negedge clk);
        cmd_valid = 1; cmd_act = act; cmd_addr = addr; cmd_date = date; cmd_amt = amt;
        @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cmd_valid = 0;
            mem_rsp_valid = 0;
            if (out_valid) begin
                r_lat = c + 1; r_err = err_msg; r_mask = err_mask; r_cmp = complete;
                break;
            end
            if (rsp_due) begin
                mem_rsp_valid = 1; mem_rsp_rdata = mem0[rsp_addr]; rsp_due = 0;
            end
            mem_req_ready = 1;
            if (mem_req_valid) begin
                if (have_cap && ({mem_req_we, mem_req_addr, mem_req_wdata} !== cap)) r_stable = 0;
                cap = {mem_req_we, mem_req_addr, mem_req_wdata};
                have_cap = 1;
                if (mem_req_we && stall_left > 0) begin
                    mem_req_ready = 0;
                    stall_left--;
                end else begin
                    have_cap = 0;
                    if (mem_req_we) begin
                        r_nwr++; r_wd = mem_req_wdata; mem0[mem_req_addr] = mem_req_wdata;
                    end else begin
                        r_nrd++; rsp_due = 1; rsp_addr = mem_req_addr;
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_act = 0; cmd_addr = 0; cmd_date = 0; cmd_amt = '0;
        cache_flush = 0; mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_rdata = '0;
        rst_n_1 = 0; cmd_valid_1 = 0; cmd_act_1 = 0; cmd_addr_1 = 0; cmd_date_1 = 0; cmd_amt_1 = '0;
        cache_flush_1 = 0; mem_req_ready_1 = 1; mem_rsp_valid_1 = 0; mem_rsp_rdata_1 = '0;
        for (int i = 0; i < 256; i++) mem0[i] = '0;
        mem0[3] = rec4(0, 0, 0, 0, 4'd3, 5'd15);
        mem0[7] = rec4(0, 0, 0, 960, 4'd6, 5'd1);
        mem0[8] = rec4(0, 0, 0, 960, 4'd6, 5'd1);
        mem0[9] = rec4(0, 0, 4000, 100, 4'd2, 5'd10);
        mem0[5] = rec4(100, 100, 100, 100, 4'd12, 5'd31);
        repeat (2) @(negedge clk);

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_we", mem_req_we, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_req_wdata", mem_req_wdata, 0);
        chk("rst_out", {out_valid, err_msg, err_mask, complete}, 0);
        chk("rst1_out", {cmd_ready_1, mem_req_valid_1, out_valid_1, err_msg_1, err_mask_1}, 11'h400);
        rst_n = 1; rst_n_1 = 1;

        run_cmd(2'd2, 8'd3, {4'd3, 5'd15}, '0, 0);
        chk("chk_eq_err", r_err, 0); chk("chk_eq_cmp", r_cmp, 1);
        chk("chk_eq_lat", r_lat, 4); chk("chk_eq_nwr", r_nwr, 0);
        @(negedge clk);
        chk("idle_err_zero", {out_valid, err_msg, err_mask}, 0);

        run_cmd(2'd2, 8'd3, {4'd3, 5'd16}, '0, 0);
        chk("chk_exp_err", r_err, 1); chk("chk_exp_cmp", r_cmp, 0);
        chk("chk_exp_hit_lat", r_lat, 2); chk("chk_exp_nrd", r_nrd, 0); chk("chk_exp_nwr", r_nwr, 0);

        run_cmd(2'd3, 8'd3, {4'd3, 5'd14}, '0, 0);
        chk("act3_err", r_err, 0); chk("act3_lat", r_lat, 2);

        run_cmd(2'd0, 8'd7, {4'd3, 5'd1}, {12'd0, 12'd0, 12'd0, 12'd960}, 0);
        chk("make_ok_err", r_err, 0); chk("make_ok_nwr", r_nwr, 1);
        chk("make_ok_wd", r_wd, rec4(0, 0, 0, 0, 4'd6, 5'd1)); chk("make_ok_lat", r_lat, 5);

        run_cmd(2'd0, 8'd8, {4'd3, 5'd1}, {12'd0, 12'd0, 12'd0, 12'd961}, 0);
        chk("make_short_err", r_err, 2); chk("make_short_mask", r_mask, 4'b0001);
        chk("make_short_nwr", r_nwr, 0); chk("make_short_lat", r_lat, 4);

        run_cmd(2'd0, 8'd8, {4'd7, 5'd1}, {12'd0, 12'd0, 12'd0, 12'd961}, 0);
        chk("make_exp_err", r_err, 1); chk("make_exp_mask", r_mask, 0); chk("make_exp_lat", r_lat, 2);

        run_cmd(2'd1, 8'd9, {4'd4, 5'd4}, {12'd0, 12'd0, 12'd200, 12'd5}, 0);
        chk("sup_of_err", r_err, 3); chk("sup_of_mask", r_mask, 4'b0010);
        chk("sup_of_wd", r_wd, rec4(0, 0, 4095, 105, 4'd4, 5'd4)); chk("sup_of_lat", r_lat, 5);

        run_cmd(2'd0, 8'd5, {4'd1, 5'd1}, {12'd1, 12'd1, 12'd1, 12'd1}, 0);
        chk("a5_first_nrd", r_nrd, 1); chk("a5_first_cmp", r_cmp, 1);
        chk("a5_first_wd", r_wd, rec4(99, 99, 99, 99, 4'd12, 5'd31));

        run_cmd(2'd0, 8'd5, {4'd1, 5'd1}, {12'd1, 12'd1, 12'd1, 12'd1}, 0);
        chk("a5_hit_nrd", r_nrd, 0); chk("a5_hit_lat", r_lat, 3);
        chk("a5_hit_wd", r_wd, rec4(98, 98, 98, 98, 4'd12, 5'd31));

        @(negedge clk); cache_flush = 1;
        @(negedge clk); cache_flush = 0;
        run_cmd(2'd0, 8'd5, {4'd1, 5'd1}, {12'd1, 12'd1, 12'd1, 12'd1}, 0);
        chk("a5_flush_nrd", r_nrd, 1); chk("a5_flush_lat", r_lat, 5);
        chk("a5_flush_wd", r_wd, rec4(97, 97, 97, 97, 4'd12, 5'd31));

        run_cmd(2'd0, 8'd5, {4'd1, 5'd1}, {12'd1, 12'd1, 12'd1, 12'd1}, 4);
        chk("stall_lat", r_lat, 7); chk("stall_stable", r_stable, 1);
        chk("stall_wd", r_wd, rec4(96, 96, 96, 96, 4'd12, 5'd31));

        // Reset while waiting for a read; the response then turns up late.
        @(negedge clk);
        cmd_valid = 1; cmd_act = 0; cmd_addr = 8'd20; cmd_date = {4'd1, 5'd1}; cmd_amt = '0;
        @(negedge clk); cmd_valid = 0;
        chk("rr_req_valid", mem_req_valid, 1); mem_req_ready = 1;
        @(negedge clk);
        chk("rr_in_wait", {mem_req_valid, cmd_ready}, 0);
        rst_n = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk); mem_rsp_valid = 1; mem_rsp_rdata = rec4(1, 2, 3, 4, 4'd9, 5'd9);
        @(negedge clk); mem_rsp_valid = 0;
        chk("rr_after_ready", cmd_ready, 1);
        chk("rr_after_req", {mem_req_valid, mem_req_we, mem_req_addr}, 0);
        chk("rr_after_wdata", mem_req_wdata, 0);
        chk("rr_after_out", {out_valid, err_msg, err_mask, complete}, 0);
        run_cmd(2'd0, 8'd5, {4'd1, 5'd1}, {12'd1, 12'd1, 12'd1, 12'd1}, 0);
        chk("rr_cache_cold_nrd", r_nrd, 1);
        chk("rr_cache_cold_wd", r_wd, rec4(95, 95, 95, 95, 4'd12, 5'd31));

        // 6 x 10-bit: supply saturation on the top ingredient, then reset mid-read.
        @(negedge clk);
        cmd_valid_1 = 1; cmd_act_1 = 2'd1; cmd_addr_1 = 8'd2; cmd_date_1 = {4'd5, 5'd20};
        cmd_amt_1 = {10'd30, 10'd0, 10'd0, 10'd0, 10'd0, 10'd5};
        @(negedge clk); cmd_valid_1 = 0;
        chk("p6_rd_req", {mem_req_valid_1, mem_req_we_1, mem_req_addr_1}, {1'b1, 1'b0, 8'd2});
        @(negedge clk);
        mem_rsp_valid_1 = 1;
        mem_rsp_rdata_1 = {10'd1000, 10'd0, 10'd0, 10'd0, 10'd0, 10'd7, 4'd1, 5'd1};
        @(negedge clk); mem_rsp_valid_1 = 0;
        @(negedge clk);
        chk("p6_wr_req", {mem_req_valid_1, mem_req_we_1}, 2'b11);
        chk("p6_wr_data", mem_req_wdata_1, {10'd1023, 10'd0, 10'd0, 10'd0, 10'd0, 10'd12, 4'd5, 5'd20});
        @(negedge clk);
        chk("p6_resp", {out_valid_1, err_msg_1, err_mask_1, complete_1}, {1'b1, 2'd3, 6'b100000, 1'b0});

        @(negedge clk);
        cmd_valid_1 = 1; cmd_act_1 = 2'd0; cmd_addr_1 = 8'd4; cmd_amt_1 = '0;
        @(negedge clk); cmd_valid_1 = 0;
        chk("p6_rr_req", mem_req_valid_1, 1);
        @(negedge clk); rst_n_1 = 0;
        @(negedge clk); rst_n_1 = 1;
        @(negedge clk); mem_rsp_valid_1 = 1; mem_rsp_rdata_1 = {c_R1{1'b1}};
        @(negedge clk); mem_rsp_valid_1 = 0;
        chk("p6_rr_idle", {cmd_ready_1, mem_req_valid_1, mem_req_we_1, mem_req_addr_1}, {1'b1, 10'd0});
        chk("p6_rr_wdata", mem_req_wdata_1, 0);
        chk("p6_rr_out", {out_valid_1, err_msg_1, err_mask_1, complete_1}, 0);
        @(negedge clk);
        chk("p6_rr_still_idle", {out_valid_1, mem_req_valid_1}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bev_param_ctrl.md
# bev_param_ctrl

Parametrised beverage-station controller: accepts a single-beat command (make drink, supply, check date) for one box record, fetches the record from the memory bridge, evaluates expiry / shortage / overflow per ingredient, and writes back on success. Generalises the fixed 4×12-bit BEV controller to `NUM_ING` ingredients of `ING_W` bits. Adds a one-entry write-through record cache that skips the memory read on a repeat address, and a per-ingredient error mask. Sits between the command decoder and the memory bridge.

## Interface
- `NUM_ING`, 4: number of ingredients per record.
- `ING_W`, 12: ingredient counter width.
- `ADDR_W`, 8: box address width.
- `REC_W`, derived = `NUM_ING*ING_W+9`: record width, laid out as {ing[NUM_ING-1]…ing[0], mon[3:0], day[4:0]}.
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_act` in 2: 0 make, 1 supply, 2 check; 3 is treated as check.
- `cmd_addr` in ADDR_W: box number.
- `cmd_date` in 9: today's date {mon, day}.
- `cmd_amt` in NUM_ING*ING_W: required amounts (make) or supply amounts (supply).
- `cache_flush` in 1: invalidate the cache entry.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_we` out 1, `mem_req_addr` out ADDR_W, `mem_req_wdata` out REC_W: memory request channel.
- `mem_rsp_valid` in 1, `mem_rsp_rdata` in REC_W: read response.
- `out_valid` out 1: one-cycle result pulse.
- `err_msg` out 2: 0 No_Err, 1 No_Exp, 2 No_Ing, 3 Ing_OF.
- `err_mask` out NUM_ING: offending ingredients.
- `complete` out 1: `out_valid && err_msg==No_Err`.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, RESP.
- IDLE: on `cmd_valid`, latch the command. Cache hit (valid && addr match) → CALC. Otherwise → RD_REQ.
- RD_REQ: `mem_req_valid=1`, `we=0`. On ready → RD_WAIT.
- RD_WAIT: on `mem_rsp_valid`, latch `rdata` and fill the cache → CALC. `mem_rsp_valid` is ignored in every other state.
- CALC, check action: expired → No_Exp. Expired means `cmd mon > rec mon`, or months equal and `cmd day > rec day`. Equal date is not expired. → RESP, no write.
- CALC, make action:
  - Expiry takes priority; `err_mask=0` on No_Exp.
  - Shortage: `rec.ing[i] < amt[i]` sets `err_mask[i]` and gives No_Ing.
  - Any error → RESP with no write.
  - Success: `ing[i] -= amt[i]` (exact, ING_W bits) → WR_REQ.
- CALC, supply action:
  - Sum is ING_W+1 bits. On carry, saturate to `2^ING_W-1`, set `err_mask[i]`, report Ing_OF.
  - Date is replaced by `cmd_date`.
  - Always → WR_REQ, including on overflow.
- WR_REQ: `mem_req_valid=1`, `we=1`, wdata = updated record. The cache is updated on CALC exit. On ready → RESP. Writes are posted; there is no write response.
- RESP: `out_valid=1` with `err_msg` / `err_mask` → IDLE.
- `cache_flush` clears the valid bit at the next edge in any state. If it coincides with a cache fill or update, flush wins.

## Timing
- Reset values:
  - state IDLE; `cmd_ready=1`.
  - `mem_req_valid=0`, `mem_req_we=0`, addr/wdata 0.
  - `out_valid=0`, `err_msg=0`, `err_mask=0`, `complete=0`.
  - Cache invalid.
- Reset mid-transaction abandons it. A late `mem_rsp_valid` after reset is ignored.
- `mem_req_*` payload is stable while `mem_req_valid && !mem_req_ready`.
- Latency counted from the command-accept edge T:
  - Hit, no write: `out_valid` at T+2.
  - Hit, with write and ready already high: `out_valid` at T+3.
  - Miss adds 1 + read-response wait + ready stalls.
- `err_msg` and `err_mask` are 0 whenever `out_valid=0`.
- Back-to-back: the next command can be accepted the cycle after RESP.

## Structure
- Shared package `bev_pkg` holds:
  - action enum;
  - `err_msg` enum (No_Err, No_Exp, No_Ing, Ing_OF);
  - `date_t` {mon[3:0], day[4:0]};
  - state enum;
  - `is_expired` function.
- Sub-module `bev_rec_cache`: one entry {valid, addr, record}, with lookup, fill, update and flush ports.

## Test plan
- Check, record 03/15, today 03/15 → No_Err, `complete=1`. Today 03/16 → No_Exp. Neither case issues a write.
- Make, record ing={960,0,0,0}, need {960,0,0,0}, not expired → write with ing0=0, No_Err. Need {961,…} → No_Ing, `err_mask=4'b0001`, no write.
- Supply, ing1=4000 plus 200 (ING_W=12) → ing1 written as 4095, Ing_OF, `err_mask=4'b0010`, date updated.
- Two makes to address 5: first issues a read, second issues no read (hit); `out_valid` at T+3 with ready tied high. Then `cache_flush` followed by a make to address 5 → read reissued.
- `mem_req_ready` low for 4 cycles during WR_REQ → payload held stable, `out_valid` delayed by 4 cycles.
- `rst_n` pulsed during RD_WAIT, then the response arrives → response ignored, IDLE, all outputs at reset values. Repeat at `NUM_ING=6`, `ING_W=10`.
